// File: rtl/mac_pkg.sv
// Shared types for the mac_pipe multiply-add / multiply-accumulate datapath.
// The stage data fields are sized per stage inside mac_pipe; only control lives here.
package mac_pkg;

  typedef enum logic {
    MODE_MADD = 1'b0,
    MODE_ACC  = 1'b1
  } mac_mode_e;

  typedef struct packed {
    logic      valid;
    mac_mode_e mode;
    logic      first;
  } mac_stage_ctrl_t;

  // The result must hold a full product plus a full addend without MADD overflow.
  function automatic bit accWidthOk(input int w, input int accW);
    return accW >= 2 * w + 1;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// ACC_W-bit unsigned adder with overflow flag and optional clamp to all-ones.
// Purely combinational; mac_pipe uses it in its final stage.
module mac_sat_add #(
  parameter int ACC_W = 20,
  parameter bit SAT   = 1'b1
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W:0] wideSum;

  always_comb begin
    wideSum = {1'b0, a_i} + {1'b0, b_i};
    ovf_o   = wideSum[ACC_W];
    sum_o   = (SAT && wideSum[ACC_W]) ? {ACC_W{1'b1}} : wideSum[ACC_W-1:0];
  end

endmodule

// File: rtl/mac_pipe.sv
// Three-stage multiply-add / multiply-accumulate unit with valid/ready flow control.
// S1 captures operands, S2 holds the product, S3 adds and owns the output registers.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 20,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic             in_first,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  if (!accWidthOk(W, ACC_W)) begin : gBadWidth
    $error("mac_pipe: ACC_W must be at least 2*W+1");
  end

  mac_stage_ctrl_t   s1Ctrl_q;
  logic [W-1:0]      s1A_q;
  logic [W-1:0]      s1B_q;
  logic [W-1:0]      s1C_q;

  mac_stage_ctrl_t   s2Ctrl_q;
  logic [2*W-1:0]    s2Prod_q;
  logic [2*W-1:0]    s2Prod_d;
  logic [W-1:0]      s2C_q;

  logic              outValid_q;
  logic [ACC_W-1:0]  outData_q;
  logic              outOvf_q;
  logic [ACC_W-1:0]  acc_q;

  logic              advance;
  logic [ACC_W-1:0]  addOperand;
  logic [ACC_W-1:0]  addSum;
  logic              addOvf;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign advance  = !outValid_q || out_ready;
  assign in_ready = advance;

  assign s2Prod_d = {{W{1'b0}}, s1A_q} * {{W{1'b0}}, s1B_q};

  // A continuing ACC sample adds to the running sum; everything else adds c.
  assign addOperand = (s2Ctrl_q.mode == MODE_ACC && !s2Ctrl_q.first) ? acc_q
                                                                     : ACC_W'(s2C_q);

  mac_sat_add #(
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_satAdd (
    .a_i   (ACC_W'(s2Prod_q)),
    .b_i   (addOperand),
    .sum_o (addSum),
    .ovf_o (addOvf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Ctrl_q   <= '0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1C_q      <= '0;
      s2Ctrl_q   <= '0;
      s2Prod_q   <= '0;
      s2C_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outOvf_q   <= 1'b0;
      acc_q      <= '0;
    end else if (advance) begin
      s1Ctrl_q   <= '{valid: in_valid, mode: mac_mode_e'(in_mode), first: in_first};
      s1A_q      <= in_a;
      s1B_q      <= in_b;
      s1C_q      <= in_c;
      s2Ctrl_q   <= s1Ctrl_q;
      s2Prod_q   <= s2Prod_d;
      s2C_q      <= s1C_q;
      outValid_q <= s2Ctrl_q.valid;
      if (s2Ctrl_q.valid) begin
        outData_q <= addSum;
        outOvf_q  <= addOvf;
        // The stored sum is the clamped value, so saturation sticks across the chain.
        if (s2Ctrl_q.mode == MODE_ACC) begin
          acc_q <= addSum;
        end
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_ovf   = outOvf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe: three instances (20-bit saturating, 17-bit
// saturating, 17-bit wrapping) share stimulus and are scored against an arithmetic model.
module tb_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inValid;
  logic        inMode;
  logic        inFirst;
  logic        outReady;
  logic [7:0]  inA;
  logic [7:0]  inB;
  logic [7:0]  inC;
  logic [2:0]  inReadyV;
  logic [2:0]  outValidV;
  logic [2:0]  outOvfV;
  logic [19:0] outData0;
  logic [16:0] outData1;
  logic [16:0] outData2;
  logic [63:0] obsData [3];

  assign obsData[0] = 64'(outData0);
  assign obsData[1] = 64'(outData1);
  assign obsData[2] = 64'(outData2);

  mac_pipe #(.W(8), .ACC_W(20), .SAT(1'b1)) dut20 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyV[0]),
    .in_mode(inMode), .in_first(inFirst), .in_a(inA), .in_b(inB), .in_c(inC),
    .out_valid(outValidV[0]), .out_ready(outReady), .out_data(outData0), .out_ovf(outOvfV[0])
  );

  mac_pipe #(.W(8), .ACC_W(17), .SAT(1'b1)) dut17Sat (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyV[1]),
    .in_mode(inMode), .in_first(inFirst), .in_a(inA), .in_b(inB), .in_c(inC),
    .out_valid(outValidV[1]), .out_ready(outReady), .out_data(outData1), .out_ovf(outOvfV[1])
  );

  mac_pipe #(.W(8), .ACC_W(17), .SAT(1'b0)) dut17Wrap (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyV[2]),
    .in_mode(inMode), .in_first(inFirst), .in_a(inA), .in_b(inB), .in_c(inC),
    .out_valid(outValidV[2]), .out_ready(outReady), .out_data(outData2), .out_ovf(outOvfV[2])
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int accWidth [3] = '{20, 17, 17};
  bit accSat   [3] = '{1'b1, 1'b1, 1'b0};
  longint unsigned modelAcc [3];
  longint unsigned expQ0 [$];
  longint unsigned expQ1 [$];
  longint unsigned expQ2 [$];
  bit lastAccept;

  // Expected entries pack the overflow flag at bit 40 above the result value.
  function automatic longint unsigned modelResult(input int idx, input logic mode,
                                                  input logic first, input logic [7:0] a,
                                                  input logic [7:0] b, input logic [7:0] c);
    longint unsigned lim;
    longint unsigned base;
    longint unsigned sum;
    longint unsigned res;
    bit ovf;
    lim  = 64'd1 << accWidth[idx];
    base = (mode && !first) ? modelAcc[idx] : longint'(c);
    sum  = longint'(a) * longint'(b) + base;
    ovf  = sum >= lim;
    res  = !ovf ? sum : (accSat[idx] ? lim - 1 : sum - lim);
    if (mode) modelAcc[idx] = res;
    return (longint'(ovf) << 40) | res;
  endfunction

  function automatic int queueSize(input int idx);
    case (idx)
      0:       return expQ0.size();
      1:       return expQ1.size();
      default: return expQ2.size();
    endcase
  endfunction

  function automatic void pushExp(input int idx, input longint unsigned v);
    case (idx)
      0:       expQ0.push_back(v);
      1:       expQ1.push_back(v);
      default: expQ2.push_back(v);
    endcase
  endfunction

  function automatic longint unsigned popExp(input int idx);
    case (idx)
      0:       return expQ0.pop_front();
      1:       return expQ1.pop_front();
      default: return expQ2.pop_front();
    endcase
  endfunction

  function automatic void clearModel();
    expQ0.delete();
    expQ1.delete();
    expQ2.delete();
    for (int i = 0; i < 3; i++) modelAcc[i] = 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic mode, input logic first,
                               input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    inValid = valid;
    inMode  = mode;
    inFirst = first;
    inA     = a;
    inB     = b;
    inC     = c;
  endtask

  // One clock: score handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    longint unsigned e;
    @(negedge clk);
    lastAccept = 1'b0;
    if (reset) begin
      clearModel();
    end else begin
      lastAccept = inValid && inReadyV[0];
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("in_ready[%0d]", i), 64'(inReadyV[i]),
                    64'(!outValidV[i] || outReady));
        if (inValid && inReadyV[i])
          pushExp(i, modelResult(i, inMode, inFirst, inA, inB, inC));
        if (outValidV[i] && outReady) begin
          checkOutput($sformatf("output_expected[%0d]", i), 64'(queueSize(i) != 0), 64'd1);
          if (queueSize(i) != 0) begin
            e = popExp(i);
            checkOutput($sformatf("out_data[%0d]", i), obsData[i], 64'(e & 64'hFF_FFFF_FFFF));
            checkOutput($sformatf("out_ovf[%0d]", i), 64'(outOvfV[i]), 64'(e >> 40));
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    inValid  = 1'b0;
    outReady = 1'b1;
    n = 0;
    while ((queueSize(0) + queueSize(1) + queueSize(2)) != 0 && n < 30) begin
      tick();
      n++;
    end
    checkOutput("drain_pending", 64'(queueSize(0) + queueSize(1) + queueSize(2)), 64'd0);
  endtask

  initial begin
    logic [7:0] sa [8];
    logic [7:0] sb [8];
    logic [7:0] sc [8];
    logic       sm [8];
    logic       sf [8];
    int sent;
    int stall;
    int cyc;

    reset    = 1'b1;
    outReady = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    clearModel();
    tick();
    tick();
    checkOutput("reset_out_valid", 64'(outValidV), 64'd0);
    checkOutput("reset_out_ovf", 64'(outOvfV), 64'd0);
    checkOutput("reset_out_data0", obsData[0], 64'd0);
    checkOutput("reset_out_data1", obsData[1], 64'd0);
    checkOutput("reset_out_data2", obsData[2], 64'd0);
    reset = 1'b0;

    // MADD 3*5+7 driven after edge 0: visible after edge 3.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 8'd5, 8'd7);
    tick();
    inValid = 1'b0;
    checkOutput("latency_edge1", 64'(outValidV), 64'd0);
    tick();
    checkOutput("latency_edge2", 64'(outValidV), 64'd0);
    tick();
    checkOutput("latency_edge3", 64'(outValidV), 64'b111);
    drain();

    applyStimulus(1'b1, 1'b0, 1'b1, 8'd255, 8'd255, 8'd255);
    tick();
    drain();

    // Accumulate chain with an interleaved MADD that must not disturb the sum.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd2, 8'd3, 8'd10);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd4, 8'd4, 8'd99);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 8'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 8'd5, 8'd7);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 8'd0);
    tick();
    drain();

    // Overflow chain: 17-bit instances saturate or wrap on the third sample.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd255, 8'd255, 8'd0);
    tick();
    tick();
    drain();

    // Backpressure: 8 back-to-back samples, 4-cycle output stall once data appears.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
      sc[i] = 8'($urandom);
      sm[i] = 1'($urandom);
      sf[i] = (i == 0) ? 1'b1 : 1'($urandom);
    end
    sent  = 0;
    stall = -1;
    cyc   = 0;
    while ((sent < 8 || (queueSize(0) + queueSize(1) + queueSize(2)) != 0) && cyc < 100) begin
      if (stall < 0 && outValidV[0]) stall = 4;
      outReady = !(stall > 0);
      if (sent < 8) applyStimulus(1'b1, sm[sent], sf[sent], sa[sent], sb[sent], sc[sent]);
      else inValid = 1'b0;
      tick();
      if (stall > 0) stall--;
      if (lastAccept) sent++;
      cyc++;
    end
    checkOutput("bp_all_sent", 64'(sent), 64'd8);
    checkOutput("bp_stall_seen", 64'(stall), 64'd0);
    drain();

    // Reset with samples in flight: nothing from before it may emerge.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd9, 8'd9, 8'd9);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd8, 8'd8, 8'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd7);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    inValid = 1'b0;
    checkOutput("reset_mid_out_valid", 64'(outValidV), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd6, 8'd7, 8'd0);
    tick();
    drain();

    // Random traffic with random source gaps and sink stalls.
    inValid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!inValid || lastAccept)
        applyStimulus(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      8'($urandom), 8'($urandom), 8'($urandom));
      outReady = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
